// File: rtl/idexe_pipe_reg_pkg.sv
// Shared pipeline definitions for the ID/EXE stage register.
// Holds the memory-op and ALU-op encodings and the control bundle that
// travels with each instruction. The bundle's NOP value is used on
// flush, bubble and reset.
package idexe_pipe_reg_pkg;

    // Memory-op encodings. MEM_NONE marks "no memory access".
    localparam logic [2:0] MEM_NONE = 3'b111;
    localparam logic [2:0] MEM_LD_B = 3'b000;
    localparam logic [2:0] MEM_LD_H = 3'b010;
    localparam logic [2:0] MEM_LD_W = 3'b011;

    localparam logic [3:0] ALU_NOP  = 4'b0000;

    // Control side of the stage register. Data fields live separately
    // because their width is a module parameter.
    typedef struct packed {
        logic       valid;
        logic       we;
        logic [2:0] mem_reg;
        logic [3:0] aluop;
        logic [4:0] dreg;
        logic [4:0] rega;
        logic [4:0] regb;
    } ctrl_t;

    localparam ctrl_t NOP_CTRL = '{
        valid:   1'b0,
        we:      1'b0,
        mem_reg: MEM_NONE,
        aluop:   ALU_NOP,
        dreg:    5'd0,
        rega:    5'd0,
        regb:    5'd0
    };

endpackage

// File: rtl/idexe_pipe_reg_if.sv
// ID/EXE bus: decoded ID-stage fields and hazard controls in, registered
// EXE-stage copies, fetch write enables, perf counters and error flags out.
//   slave  : the pipeline register itself
//   master : the surrounding pipeline (or a testbench)
interface idexe_pipe_reg_if #(
    parameter int DW = 32
);
    // hazard / control inputs
    logic          _stall_en;   // active-low load-use stall
    logic          bubble;
    logic          flush;

    // ID-stage fields
    logic          id_valid;
    logic [DW-1:0] id_pc;
    logic [DW-1:0] id_a;
    logic [DW-1:0] id_b;
    logic [DW-1:0] id_imm;
    logic [4:0]    id_rega;
    logic [4:0]    id_regb;
    logic [4:0]    id_dreg;
    logic          id_we;
    logic [2:0]    id_mem_reg;
    logic [3:0]    id_aluop;

    // EXE-stage copies
    logic          exe_valid;
    logic [DW-1:0] exe_pc;
    logic [DW-1:0] exe_a;
    logic [DW-1:0] exe_b;
    logic [DW-1:0] exe_imm;
    logic [4:0]    exe_rega;
    logic [4:0]    exe_regb;
    logic [4:0]    exe_wb_dreg;
    logic          exe_wb_we;
    logic [2:0]    exe_mem_mem_reg;
    logic [3:0]    exe_aluop;

    // fetch enables, counters, flags
    logic          pc_we;
    logic          ifid_we;
    logic [15:0]   stall_cnt;
    logic [15:0]   bubble_cnt;
    logic          stall_err;
    logic          proto_err;

    modport slave (
        input  _stall_en, bubble, flush,
        input  id_valid, id_pc, id_a, id_b, id_imm,
        input  id_rega, id_regb, id_dreg, id_we, id_mem_reg, id_aluop,
        output exe_valid, exe_pc, exe_a, exe_b, exe_imm,
        output exe_rega, exe_regb, exe_wb_dreg, exe_wb_we,
        output exe_mem_mem_reg, exe_aluop,
        output pc_we, ifid_we, stall_cnt, bubble_cnt, stall_err, proto_err
    );

    modport master (
        output _stall_en, bubble, flush,
        output id_valid, id_pc, id_a, id_b, id_imm,
        output id_rega, id_regb, id_dreg, id_we, id_mem_reg, id_aluop,
        input  exe_valid, exe_pc, exe_a, exe_b, exe_imm,
        input  exe_rega, exe_regb, exe_wb_dreg, exe_wb_we,
        input  exe_mem_mem_reg, exe_aluop,
        input  pc_we, ifid_we, stall_cnt, bubble_cnt, stall_err, proto_err
    );

endinterface

// File: rtl/idexe_pipe_reg_sat_counter16.sv
// sat_counter16: 16-bit up counter that sticks at 16'hFFFF.
//   clk, rst : clock, synchronous active-high clear
//   inc      : add one this edge (ignored once saturated)
//   cnt      : current count
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= 16'd0;
        else if (inc && (cnt != 16'hFFFF))
            cnt <= cnt + 16'd1;
    end

endmodule

// File: rtl/idexe_pipe_reg.sv
// idexe_pipe_reg: ID/EXE pipeline register with hazard handling.
//   clk, rst : clock, synchronous active-high reset
//   bus      : idexe_pipe_reg_if.slave (ID fields and hazard controls in;
//              EXE copies, pc_we/ifid_we, counters and error flags out)
// Per edge: rst > flush > bubble > normal load. Flush and bubble both load
// a NOP. A watchdog flags stall runs longer than MAX_STALL and then freezes
// fetch until reset; proto_err flags cycles where bubble and the stall
// request disagree.
module idexe_pipe_reg
    import idexe_pipe_reg_pkg::*;
#(
    parameter int MAX_STALL = 2,
    parameter int DW        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    idexe_pipe_reg_if.slave       bus
);

    // Run counter saturates one past the limit; that is enough to tell
    // "over the limit" apart and keeps it from wrapping back to legal.
    localparam int              RUN_MAX = MAX_STALL + 1;
    localparam int              RUN_W   = $clog2(RUN_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_TOP = RUN_W'(RUN_MAX);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_STALL);

    ctrl_t         ctrl_q;
    ctrl_t         ctrl_d;
    logic [DW-1:0] pc_q, a_q, b_q, imm_q;

    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic             stall;
    logic             stall_err_q;
    logic             proto_err_q;
    logic [15:0]      stall_cnt_w;
    logic [15:0]      bubble_cnt_w;

    assign stall = ~bus._stall_en;

    // ---------------------------------------------------------------
    // Stage register
    // ---------------------------------------------------------------
    always_comb begin
        ctrl_d         = NOP_CTRL;
        ctrl_d.valid   = bus.id_valid;
        ctrl_d.we      = bus.id_we;
        ctrl_d.mem_reg = bus.id_mem_reg;
        ctrl_d.aluop   = bus.id_aluop;
        ctrl_d.dreg    = bus.id_dreg;
        ctrl_d.rega    = bus.id_rega;
        ctrl_d.regb    = bus.id_regb;
    end

    // Flush and bubble only look at themselves, never at _stall_en, so an
    // inconsistent bubble/_stall_en pair still resolves on bubble alone.
    always_ff @(posedge clk) begin
        if (rst || bus.flush || bus.bubble) begin
            ctrl_q <= NOP_CTRL;
            pc_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            imm_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            pc_q   <= bus.id_pc;
            a_q    <= bus.id_a;
            b_q    <= bus.id_b;
            imm_q  <= bus.id_imm;
        end
    end

    assign bus.exe_valid       = ctrl_q.valid;
    assign bus.exe_wb_we       = ctrl_q.we;
    assign bus.exe_mem_mem_reg = ctrl_q.mem_reg;
    assign bus.exe_aluop       = ctrl_q.aluop;
    assign bus.exe_wb_dreg     = ctrl_q.dreg;
    assign bus.exe_rega        = ctrl_q.rega;
    assign bus.exe_regb        = ctrl_q.regb;
    assign bus.exe_pc          = pc_q;
    assign bus.exe_a           = a_q;
    assign bus.exe_b           = b_q;
    assign bus.exe_imm         = imm_q;

    // ---------------------------------------------------------------
    // Stall watchdog and protocol check
    // ---------------------------------------------------------------
    always_comb begin
        run_d = run_q;
        if (!stall)
            run_d = '0;
        else if (run_q != RUN_TOP)
            run_d = run_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q       <= '0;
            stall_err_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            run_q <= run_d;
            // this edge makes the run MAX_STALL+1 long
            if (stall && (run_q >= RUN_LIM))
                stall_err_q <= 1'b1;
            // bubble must be the inverse of _stall_en
            if (bus.bubble == bus._stall_en)
                proto_err_q <= 1'b1;
        end
    end

    // Flush deliberately does not gate fetch; only a stall or a tripped
    // watchdog does.
    assign bus.pc_we     = bus._stall_en & ~stall_err_q;
    assign bus.ifid_we   = bus._stall_en & ~stall_err_q;
    assign bus.stall_err = stall_err_q;
    assign bus.proto_err = proto_err_q;

    // ---------------------------------------------------------------
    // Performance counters
    // ---------------------------------------------------------------
    sat_counter16 u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall),
        .cnt (stall_cnt_w)
    );

    sat_counter16 u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bus.bubble & ~bus.flush),
        .cnt (bubble_cnt_w)
    );

    assign bus.stall_cnt  = stall_cnt_w;
    assign bus.bubble_cnt = bubble_cnt_w;

endmodule

// File: tb/tb_idexe_pipe_reg.sv
// Self-checking bench for idexe_pipe_reg: directed scenarios followed by
// randomized traffic, compared against a cycle-level reference model.
module tb_idexe_pipe_reg;

    localparam int DW        = 32;
    localparam int MAX_STALL = 2;

    logic clk;
    logic rst;

    idexe_pipe_reg_if #(.DW(DW)) bus ();

    idexe_pipe_reg #(.MAX_STALL(MAX_STALL), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cmp_cnt = 0;
    int err_cnt = 0;

    // reference model state
    bit          m_init = 0;
    logic        m_valid, m_we;
    logic [31:0] m_pc, m_a, m_b, m_imm;
    logic [4:0]  m_rega, m_regb, m_dreg;
    logic [2:0]  m_mem;
    logic [3:0]  m_alu;
    int          m_scnt, m_bcnt, m_run;
    logic        m_serr, m_perr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm,
                          input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                          input logic we, input logic [2:0] mem, input logic [3:0] alu);
        bus.id_valid = v;  bus.id_pc = pc;  bus.id_a = a;  bus.id_b = b;
        bus.id_imm = imm;  bus.id_rega = ra; bus.id_regb = rb; bus.id_dreg = rd;
        bus.id_we = we;    bus.id_mem_reg = mem; bus.id_aluop = alu;
    endtask

    task automatic rand_id();
        set_id(1'($urandom), $urandom, $urandom, $urandom, $urandom,
               5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
               3'($urandom), 4'($urandom));
    endtask

    task automatic model_nop();
        m_valid = 0; m_we = 0; m_mem = 3'b111; m_alu = 4'b0000;
        m_dreg = 0;  m_rega = 0; m_regb = 0;
        m_pc = 0; m_a = 0; m_b = 0; m_imm = 0;
    endtask

    task automatic check_all();
        chk("exe_valid",   64'(bus.exe_valid),       64'(m_valid));
        chk("exe_pc",      64'(bus.exe_pc),          64'(m_pc));
        chk("exe_a",       64'(bus.exe_a),           64'(m_a));
        chk("exe_b",       64'(bus.exe_b),           64'(m_b));
        chk("exe_imm",     64'(bus.exe_imm),         64'(m_imm));
        chk("exe_rega",    64'(bus.exe_rega),        64'(m_rega));
        chk("exe_regb",    64'(bus.exe_regb),        64'(m_regb));
        chk("exe_wb_dreg", 64'(bus.exe_wb_dreg),     64'(m_dreg));
        chk("exe_wb_we",   64'(bus.exe_wb_we),       64'(m_we));
        chk("exe_mem",     64'(bus.exe_mem_mem_reg), 64'(m_mem));
        chk("exe_aluop",   64'(bus.exe_aluop),       64'(m_alu));
        chk("stall_cnt",   64'(bus.stall_cnt),       64'(m_scnt));
        chk("bubble_cnt",  64'(bus.bubble_cnt),      64'(m_bcnt));
        chk("stall_err",   64'(bus.stall_err),       64'(m_serr));
        chk("proto_err",   64'(bus.proto_err),       64'(m_perr));
    endtask

    // One clock: apply controls, check fetch enables before the edge,
    // advance the model, check registered outputs after the edge.
    task automatic step(input logic r, input logic se, input logic bb,
                        input logic fl, input bit do_chk);
        rst = r; bus._stall_en = se; bus.bubble = bb; bus.flush = fl;
        #1;
        if (do_chk && m_init) begin
            chk("pc_we",   64'(bus.pc_we),   64'(se & ~m_serr));
            chk("ifid_we", 64'(bus.ifid_we), 64'(se & ~m_serr));
        end
        @(posedge clk);
        #1;
        if (r) begin
            model_nop();
            m_scnt = 0; m_bcnt = 0; m_run = 0; m_serr = 0; m_perr = 0;
            m_init = 1;
        end else begin
            if (fl || bb) model_nop();
            else begin
                m_valid = bus.id_valid; m_pc = bus.id_pc; m_a = bus.id_a;
                m_b = bus.id_b; m_imm = bus.id_imm; m_rega = bus.id_rega;
                m_regb = bus.id_regb; m_dreg = bus.id_dreg; m_we = bus.id_we;
                m_mem = bus.id_mem_reg; m_alu = bus.id_aluop;
            end
            if (!se)       m_scnt = (m_scnt < 65535) ? m_scnt + 1 : 65535;
            if (bb && !fl) m_bcnt = (m_bcnt < 65535) ? m_bcnt + 1 : 65535;
            m_run = se ? 0 : m_run + 1;
            if (m_run > MAX_STALL) m_serr = 1;
            if (bb == se) m_perr = 1;
        end
        if (do_chk && m_init) check_all();
    endtask

    initial begin
        rst = 1'b1;
        bus._stall_en = 1'b1; bus.bubble = 1'b0; bus.flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset state
        rand_id();
        step(1, 1, 0, 0, 1);
        chk("rst_mem_none", 64'(bus.exe_mem_mem_reg), 64'h7);

        // normal load
        set_id(1, 32'h40, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd5, 1, 3'b000, 4'h3);
        step(0, 1, 0, 0, 1);
        chk("nl_pc",   64'(bus.exe_pc),      64'h40);
        chk("nl_dreg", 64'(bus.exe_wb_dreg), 64'd5);
        chk("nl_we",   64'(bus.exe_wb_we),   64'd1);

        // load-use: stall + bubble for one cycle
        rand_id();
        step(0, 0, 1, 0, 1);
        chk("lu_stall_cnt",  64'(bus.stall_cnt),  64'd1);
        chk("lu_bubble_cnt", 64'(bus.bubble_cnt), 64'd1);
        rand_id(); step(0, 1, 0, 0, 1);

        // flush with bubble during a stall
        rand_id();
        step(0, 0, 1, 1, 1);
        chk("fl_bubble_cnt", 64'(bus.bubble_cnt), 64'd1);
        chk("fl_stall_cnt",  64'(bus.stall_cnt),  64'd2);
        rand_id(); step(0, 1, 0, 0, 1);

        // watchdog: three consecutive stalls trips it
        for (int i = 0; i < 3; i++) begin rand_id(); step(0, 0, 1, 0, 1); end
        chk("wd_err", 64'(bus.stall_err), 64'd1);
        for (int i = 0; i < 2; i++) begin rand_id(); step(0, 1, 0, 0, 1); end
        chk("wd_pc_we_held", 64'(bus.pc_we), 64'd0);
        rand_id(); step(1, 0, 1, 0, 1);   // reset mid-stall
        rand_id(); step(0, 1, 0, 0, 1);   // pc_we follows _stall_en again

        // protocol error: stall without bubble still loads normally
        rand_id(); step(0, 0, 0, 0, 1);
        chk("pe_flag", 64'(bus.proto_err), 64'd1);
        for (int i = 0; i < 3; i++) begin rand_id(); step(0, 1, 0, 0, 1); end

        // saturation: preload stall_cnt to FFFE, then 3 more stalls
        rand_id(); step(1, 1, 0, 0, 1);
        for (int i = 0; i < 65534; i++) step(0, 0, 1, 0, 0);
        chk("sat_pre", 64'(bus.stall_cnt), 64'hFFFE);
        for (int i = 0; i < 3; i++) begin rand_id(); step(0, 0, 1, 0, 1); end
        chk("sat_top", 64'(bus.stall_cnt), 64'hFFFF);
        rand_id(); step(1, 1, 0, 0, 1);
        chk("sat_rst_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("sat_rst_mem", 64'(bus.exe_mem_mem_reg), 64'h7);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic r, se, bb, fl;
            r  = ($urandom_range(0, 39) == 0);
            se = ($urandom_range(0, 2) != 0);
            bb = ($urandom_range(0, 9) == 0) ? se : ~se;
            fl = ($urandom_range(0, 7) == 0);
            rand_id();
            step(r, se, bb, fl, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
